hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LATENCY, default 32, multiply/divide cycles, legal range 2..255.
REQ-003 SHALL have port clock, input, 1, single clock for the whole block; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports id_valid/id_wr_en/id_is_load/id_is_store/id_is_md, input, 1 each, decode-stage instruction attributes.
REQ-006 SHALL have ports id_rs_a/id_rs_b/id_rd, input, REG_AW each, decode-stage source and destination register numbers.
REQ-007 SHALL have ports id_rs_a_use/id_rs_b_use, input, 1 each, source actually read; store data is rs_b.
REQ-008 SHALL have port flush, input, 1, discard the decode-stage instruction.
REQ-009 SHALL have port stall, output, 1, hold fetch/decode and insert an EX bubble.
REQ-010 SHALL have ports ex_fwd_a/ex_fwd_b, output, 2 each, EX operand select: 0 regfile, 1 from MEM, 2 from WB.
REQ-011 SHALL have port mem_fwd_st, output, 1, select WB result as store data in MEM.
REQ-012 SHALL have ports md_busy/md_done, output, 1 each, multdiv in progress / single-cycle completion pulse.

Function
REQ-013 SHALL keep shadow entries EX, MEM, WB of {valid, rd, wr_en, is_load, is_store, rs_a, rs_b, rs_a_use, rs_b_use}, advancing EX->MEM->WB every cycle.
REQ-014 SHALL load EX from decode when id_valid && !stall && !flush; otherwise EX becomes invalid (bubble).
REQ-015 SHALL treat an entry as a writer only if valid && wr_en && rd != 0; register 0 is never forwarded or stalled on.
REQ-016 SHALL drive ex_fwd_a = 1 when EX.rs_a_use and the MEM writer rd equals EX.rs_a, else 2 on a WB writer match, else 0; MEM has priority; ex_fwd_b identical on rs_b.
REQ-017 SHALL assert stall combinationally when a used decode source equals the rd of an EX writer with is_load (one-cycle load-use stall).
REQ-018 SHALL run a multdiv timer: IDLE -> BUSY on id_valid && id_is_md && !stall && !flush, loading MD_LATENCY and capturing id_rd.
REQ-019 SHALL decrement the timer each cycle in BUSY, pulse md_done exactly in the cycle the count reaches 1, then return to IDLE; md_busy equals BUSY.
REQ-020 SHALL stall while BUSY if the decode instruction is multdiv, or a used source or a writer rd equals the captured multdiv rd (nonzero).
REQ-021 SHALL ignore flush in the timer; flush never cancels an issued multdiv.
REQ-022 SHALL give flush priority over stall for EX insertion; stall still reflects the hazard terms.

Reset
REQ-023 SHALL, on reset_n low, asynchronously invalidate EX/MEM/WB, force IDLE with count 0, and drive stall, md_busy, md_done, mem_fwd_st at 0 and ex_fwd_a/b at 0.
REQ-024 SHALL abandon an in-flight multdiv on reset without asserting md_done.

Configuration
REQ-025 SHALL, with FWD_STORE_DATA_EN defined, drive mem_fwd_st = MEM.is_store && MEM.rs_b_use && WB writer rd == MEM.rs_b.
REQ-026 SHALL, without FWD_STORE_DATA_EN, tie mem_fwd_st to 0 and additionally stall one cycle when a decode store's rs_b matches an EX load writer.

Structure
REQ-027 SHALL place the stage-entry struct, forward-select encodings (FWD_RF=0, FWD_MEM=1, FWD_WB=2) and timer state enum in package hazard_pkg.
REQ-028 SHALL implement the multdiv timer as sub-module hazard_md_timer.

Verification
REQ-029 SHALL cover: add r3 then sub r5,r3,r4 back-to-back -> ex_fwd_a=1 on sub in EX; one instruction apart -> ex_fwd_a=2.
REQ-030 SHALL cover: lw r7 then add r8,r7,r1 -> stall=1 exactly one cycle, then ex_fwd_a=2 when add reaches EX.
REQ-031 SHALL cover: mul r9 with MD_LATENCY=4, then add r2,r9,r1 -> stall 4 cycles, md_done single pulse, add then issues.
REQ-032 SHALL cover: add r0 then use r0 -> no stall, ex_fwd=0; flush during load-use stall -> EX bubble, no forward.
REQ-033 SHALL cover: lw r4 then sw r4 -> with FWD_STORE_DATA_EN mem_fwd_st=1 and no stall; without it, one stall and mem_fwd_st=0.
REQ-034 SHALL cover: reset_n low mid-multdiv (count 2) -> md_busy=0, md_done never pulses, next multdiv starts from MD_LATENCY.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: pipeline shadow entry, forward-select
// encodings and the multdiv timer state. Optional feature macro: FWD_STORE_DATA_EN.
package hazard_pkg;

    // Register numbers are zero-extended into shadow entries; REG_AW must not exceed this.
    localparam int unsigned RegAwMax = 8;
    // Wide enough for MD_LATENCY up to 255.
    localparam int unsigned MdCntW = 8;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        MdIdle,
        MdBusy
    } md_state_e;

    typedef struct packed {
        logic                valid;
        logic [RegAwMax-1:0] rd;
        logic                wr_en;
        logic                is_load;
        logic                is_store;
        logic [RegAwMax-1:0] rs_a;
        logic [RegAwMax-1:0] rs_b;
        logic                rs_a_use;
        logic                rs_b_use;
    } stage_t;

    // Register 0 is hardwired, so an entry targeting it never produces a value.
    function automatic logic is_writer(input stage_t s);
        return s.valid && s.wr_en && (s.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Multiply/divide occupancy timer: counts MD_LATENCY cycles after an issue and
// remembers the destination register so dependants can be held off.
// Optional feature macro (top level only): FWD_STORE_DATA_EN.
module hazard_md_timer
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [REG_AW-1:0] rd_o
);

    md_state_e         state_q, state_d;
    logic [MdCntW-1:0] cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    // Timer state, count and captured destination register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Next state: load on issue, count down while busy, leave after the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            MdIdle: begin
                if (start_i) begin
                    state_d = MdBusy;
                    cnt_d   = MdCntW'(MD_LATENCY);
                    rd_d    = rd_i;
                end
            end
            MdBusy: begin
                cnt_d = cnt_q - MdCntW'(1);
                if (cnt_q == MdCntW'(1)) begin
                    state_d = MdIdle;
                end
            end
        endcase
    end

    assign busy_o = (state_q == MdBusy);
    assign done_o = (state_q == MdBusy) && (cnt_q == MdCntW'(1));
    assign rd_o   = rd_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB shadow tracking, operand forwarding
// selects, load-use and multdiv interlocks.
// Optional feature macro: FWD_STORE_DATA_EN (WB->MEM store-data forwarding).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              id_is_md,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs_a_use,
    input  logic              id_rs_b_use,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              mem_fwd_st,
    output logic              md_busy,
    output logic              md_done
);

    stage_t              ex_q, mem_q, wb_q, ex_d, id_entry;
    logic [RegAwMax-1:0] id_rs_a_w, id_rs_b_w, id_rd_w, md_rd_w;
    logic [REG_AW-1:0]   md_rd;
    logic                ex_wr, mem_wr, wb_wr;
    logic                use_b_lu, load_use, md_hazard, issue;
    logic                unused_stage;

    assign id_rs_a_w = RegAwMax'(id_rs_a);
    assign id_rs_b_w = RegAwMax'(id_rs_b);
    assign id_rd_w   = RegAwMax'(id_rd);
    assign md_rd_w   = RegAwMax'(md_rd);

    assign ex_wr  = is_writer(ex_q);
    assign mem_wr = is_writer(mem_q);
    assign wb_wr  = is_writer(wb_q);

`ifdef FWD_STORE_DATA_EN
    // Store data can be picked up from WB in MEM, so it never needs the load-use bubble.
    assign use_b_lu = id_rs_b_use && !id_is_store;
`else
    assign use_b_lu = id_rs_b_use;
`endif

    // Interlocks; stall stays visible even when the decode slot is being flushed.
    always_comb begin
        load_use = id_valid && ex_wr && ex_q.is_load &&
                   ((id_rs_a_use && (id_rs_a_w == ex_q.rd)) ||
                    (use_b_lu && (id_rs_b_w == ex_q.rd)));
        md_hazard = md_busy && id_valid &&
                    (id_is_md ||
                     ((md_rd_w != '0) &&
                      ((id_rs_a_use && (id_rs_a_w == md_rd_w)) ||
                       (id_rs_b_use && (id_rs_b_w == md_rd_w)) ||
                       (id_wr_en && (id_rd_w == md_rd_w)))));
        stall = load_use || md_hazard;
        issue = id_valid && !stall && !flush;
    end

    // Decode entry into EX, or a fully cleared bubble.
    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.rd       = id_rd_w;
        id_entry.wr_en    = id_wr_en;
        id_entry.is_load  = id_is_load;
        id_entry.is_store = id_is_store;
        id_entry.rs_a     = id_rs_a_w;
        id_entry.rs_b     = id_rs_b_w;
        id_entry.rs_a_use = id_rs_a_use;
        id_entry.rs_b_use = id_rs_b_use;
        ex_d              = issue ? id_entry : '0;
    end

    // Shadow pipeline advances every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // EX operand selects; the younger MEM result wins over WB.
    always_comb begin
        ex_fwd_a = FWD_RF;
        ex_fwd_b = FWD_RF;
        if (ex_q.valid && ex_q.rs_a_use) begin
            if (mem_wr && (mem_q.rd == ex_q.rs_a)) begin
                ex_fwd_a = FWD_MEM;
            end else if (wb_wr && (wb_q.rd == ex_q.rs_a)) begin
                ex_fwd_a = FWD_WB;
            end
        end
        if (ex_q.valid && ex_q.rs_b_use) begin
            if (mem_wr && (mem_q.rd == ex_q.rs_b)) begin
                ex_fwd_b = FWD_MEM;
            end else if (wb_wr && (wb_q.rd == ex_q.rs_b)) begin
                ex_fwd_b = FWD_WB;
            end
        end
    end

`ifdef FWD_STORE_DATA_EN
    assign mem_fwd_st = mem_q.valid && mem_q.is_store && mem_q.rs_b_use && wb_wr &&
                        (wb_q.rd == mem_q.rs_b);
`else
    assign mem_fwd_st = 1'b0;
`endif

    // Not every shadow field is consulted in every stage or build.
    assign unused_stage = ^{mem_q, wb_q};

    hazard_md_timer #(
        .REG_AW     (REG_AW),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .start_i (id_valid && id_is_md && !stall && !flush),
        .rd_i    (id_rd),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .rd_o    (md_rd)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LATENCY = 4). Honours FWD_STORE_DATA_EN.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid, id_wr_en, id_is_load, id_is_store, id_is_md;
    logic [4:0] id_rs_a, id_rs_b, id_rd;
    logic       id_rs_a_use, id_rs_b_use, flush;
    logic       stall, mem_fwd_st, md_busy, md_done;
    logic [1:0] ex_fwd_a, ex_fwd_b;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(
        .REG_AW     (5),
        .MD_LATENCY (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .id_is_store (id_is_store),
        .id_is_md    (id_is_md),
        .id_rs_a     (id_rs_a),
        .id_rs_b     (id_rs_b),
        .id_rd       (id_rd),
        .id_rs_a_use (id_rs_a_use),
        .id_rs_b_use (id_rs_b_use),
        .flush       (flush),
        .stall       (stall),
        .ex_fwd_a    (ex_fwd_a),
        .ex_fwd_b    (ex_fwd_b),
        .mem_fwd_st  (mem_fwd_st),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic ld, input logic st,
                         input logic md, input logic [4:0] ra, input logic ua,
                         input logic [4:0] rb, input logic ub, input logic [4:0] rd);
        id_valid = v;   id_wr_en = wr;  id_is_load = ld; id_is_store = st; id_is_md = md;
        id_rs_a  = ra;  id_rs_a_use = ua; id_rs_b = rb;  id_rs_b_use = ub; id_rd = rd;
        #1;
    endtask

    task automatic nop();                                       drive(0,0,0,0,0, 0,0, 0,0, 0);  endtask
    task automatic alu(input logic [4:0] rd, ra, rb);           drive(1,1,0,0,0, ra,1, rb,1, rd); endtask
    task automatic lw(input logic [4:0] rd, base);              drive(1,1,1,0,0, base,1, 0,0, rd); endtask
    task automatic sw(input logic [4:0] base, data);            drive(1,0,0,1,0, base,1, data,1, 0); endtask
    task automatic mul(input logic [4:0] rd, ra, rb);           drive(1,1,0,0,1, ra,1, rb,1, rd); endtask

    task automatic drain();
        int n;
        flush = 1'b0;
        nop();
        n = 0;
        while (md_busy && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int dones;
        reset_n = 1'b0;
        flush   = 1'b0;
        nop();
        #11;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_fwd_a", ex_fwd_a, 0);
        check_eq("rst_fwd_b", ex_fwd_b, 0);
        check_eq("rst_md_busy", md_busy, 0);
        check_eq("rst_md_done", md_done, 0);
        check_eq("rst_mem_fwd_st", mem_fwd_st, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Back-to-back ALU dependency: forward from MEM.
        alu(3, 1, 2);    check_eq("b2b_no_stall", stall, 0); tick();
        alu(5, 3, 4);    check_eq("b2b_sub_no_stall", stall, 0); tick();
        nop();
        check_eq("b2b_fwd_a", ex_fwd_a, 1);
        check_eq("b2b_fwd_b", ex_fwd_b, 0);
        drain();

        // One instruction apart: forward from WB.
        alu(3, 1, 2); tick();
        nop();        tick();
        alu(5, 3, 4); tick();
        nop();
        check_eq("gap_fwd_a", ex_fwd_a, 2);
        drain();

        // Both MEM and WB write r3: MEM has priority on both operands.
        alu(3, 1, 2); tick();
        alu(3, 1, 2); tick();
        alu(5, 3, 3); tick();
        nop();
        check_eq("prio_fwd_a", ex_fwd_a, 1);
        check_eq("prio_fwd_b", ex_fwd_b, 1);
        drain();

        // Load-use: exactly one stall cycle, then WB forward.
        lw(7, 1); tick();
        alu(8, 7, 1);
        check_eq("lu_stall_1", stall, 1);
        tick();
        check_eq("lu_stall_2", stall, 0);
        tick();
        nop();
        check_eq("lu_fwd_a", ex_fwd_a, 2);
        check_eq("lu_fwd_b", ex_fwd_b, 0);
        drain();

        // Load-use on rs_b of an ALU op.
        lw(7, 1); tick();
        alu(8, 1, 7);
        check_eq("lu_b_stall", stall, 1);
        drain();

        // r0 is never a hazard source.
        lw(0, 1); tick();
        alu(1, 0, 0);
        check_eq("r0_no_stall", stall, 0);
        tick();
        nop();
        check_eq("r0_fwd_a", ex_fwd_a, 0);
        check_eq("r0_fwd_b", ex_fwd_b, 0);
        drain();

        // Flush during a load-use stall: EX bubble, no forwarding.
        lw(7, 1); tick();
        alu(8, 7, 1);
        flush = 1'b1; #1;
        check_eq("flush_stall_visible", stall, 1);
        tick();
        flush = 1'b0;
        nop();
        check_eq("flush_bubble_fwd_a", ex_fwd_a, 0);
        tick();
        check_eq("flush_bubble_fwd_a_wb", ex_fwd_a, 0);
        drain();

        // Flushed producer must not be forwarded.
        alu(3, 1, 2);
        flush = 1'b1; #1;
        tick();
        flush = 1'b0;
        alu(5, 3, 4); tick();
        nop();
        check_eq("flushed_prod_fwd_a", ex_fwd_a, 0);
        drain();

        // Multdiv dependant: four stall cycles, single done pulse, then issue.
        mul(9, 1, 2);
        check_eq("md_issue_no_stall", stall, 0);
        tick();
        alu(2, 9, 1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("md_stall_%0d", i), stall, 1);
            check_eq($sformatf("md_busy_%0d", i), md_busy, 1);
            if (md_done) dones++;
            if (i == 3) check_eq("md_done_last", md_done, 1);
            tick();
        end
        check_eq("md_done_count", dones, 1);
        check_eq("md_after_stall", stall, 0);
        check_eq("md_after_busy", md_busy, 0);
        check_eq("md_after_done", md_done, 0);
        drain();

        // While busy: independent op proceeds, another multdiv or a WAW on rd stalls.
        mul(9, 1, 2); tick();
        alu(2, 5, 6);
        check_eq("md_indep_no_stall", stall, 0);
        tick();
        mul(10, 1, 2);
        check_eq("md_second_md_stall", stall, 1);
        drive(1,1,0,0,0, 1,1, 2,1, 9);
        check_eq("md_waw_stall", stall, 1);
        drain();

        // Store after load: store data forwarded in MEM, or one extra stall.
        lw(4, 1); tick();
        sw(2, 4);
`ifdef FWD_STORE_DATA_EN
        check_eq("st_no_stall", stall, 0);
        tick();
        nop();
        tick();
        check_eq("st_mem_fwd", mem_fwd_st, 1);
`else
        check_eq("st_stall", stall, 1);
        tick();
        check_eq("st_stall_release", stall, 0);
        tick();
        nop();
        check_eq("st_fwd_b", ex_fwd_b, 2);
        check_eq("st_mem_fwd_ex", mem_fwd_st, 0);
        tick();
        check_eq("st_mem_fwd", mem_fwd_st, 0);
`endif
        drain();

        // Reset during multdiv at count 2: abandoned, no done, restart from full latency.
        mul(9, 1, 2); tick();
        nop();        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mdrst_busy", md_busy, 0);
        dones = 0;
        repeat (3) begin
            tick();
            if (md_done) dones++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
            tick();
            if (md_done) dones++;
        end
        check_eq("mdrst_no_done", dones, 0);
        mul(9, 1, 2); tick();
        nop();
        n = 0;
        dones = 0;
        while (md_busy && n < 50) begin
            if (md_done) dones++;
            n++;
            tick();
        end
        check_eq("mdrst_restart_len", n, 4);
        check_eq("mdrst_restart_done", dones, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
